// File: rtl/flow_ctrl.sv
// flow_ctrl: program-counter and status-register flow control unit.
// Executes one jump / status / trap op per cycle with a RUN/TRAP state machine.
module flow_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [19:0] op_target,
    input  logic [3:0]  op_imm,
    input  logic        alu_flag_we,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_carry,
    input  logic        trap_ack,
    output logic [19:0] pc,
    output logic [4:0]  sr,
    output logic [19:0] epc,
    output logic        redirect
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    localparam logic [2:0] OP_TRAP  = 3'd0;
    localparam logic [2:0] OP_NOP   = 3'd1;
    localparam logic [2:0] OP_JMP   = 3'd2;
    localparam logic [2:0] OP_JZ    = 3'd3;
    localparam logic [2:0] OP_JS    = 3'd4;
    localparam logic [2:0] OP_JZS   = 3'd5;
    localparam logic [2:0] OP_LDSR  = 3'd6;
    localparam logic [2:0] OP_XORSR = 3'd7;

    localparam int SR_ZERO  = 0;
    localparam int SR_SIGN  = 1;
    localparam int SR_MODE  = 3;
    localparam int SR_TRAP  = 4;

    localparam logic [4:0] SR_RESET = 5'b01000;

    state_t      state_q, state_d;
    logic [19:0] pc_q, pc_d;
    logic [19:0] epc_q, epc_d;
    logic [4:0]  sr_q, sr_d;
    logic        redirect_q, redirect_d;

    logic        accept;
    logic        is_jump;
    logic        jump_taken;
    logic [19:0] jump_target;
    logic [19:0] pc_inc;

    // State register for the RUN/TRAP machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a TRAP op enters TRAP, trap_ack returns to RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && (op_code == OP_TRAP)) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Handshake output: ops are only taken while running.
    always_comb begin
        op_ready = 1'b0;
        unique case (state_q)
            ST_RUN:  op_ready = 1'b1;
            ST_TRAP: op_ready = 1'b0;
            default: op_ready = 1'b0;
        endcase
    end

    assign accept = op_valid && op_ready;
    assign pc_inc = pc_q + 20'd1;

    // Jump decode: conditions look at the flags held before this edge.
    always_comb begin
        is_jump    = 1'b0;
        jump_taken = 1'b0;
        unique case (op_code)
            OP_JMP: begin
                is_jump    = 1'b1;
                jump_taken = 1'b1;
            end
            OP_JZ: begin
                is_jump    = 1'b1;
                jump_taken = sr_q[SR_ZERO];
            end
            OP_JS: begin
                is_jump    = 1'b1;
                jump_taken = sr_q[SR_SIGN];
            end
            OP_JZS: begin
                is_jump    = 1'b1;
                jump_taken = sr_q[SR_ZERO] | sr_q[SR_SIGN];
            end
            default: begin
                is_jump    = 1'b0;
                jump_taken = 1'b0;
            end
        endcase
        if (sr_q[SR_MODE]) begin
            jump_target = op_target;
        end else begin
            jump_target = {10'b0, op_target[9:0]};
        end
    end

    // Datapath next values for pc, epc, sr and the redirect pulse.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        sr_d       = sr_q;
        redirect_d = 1'b0;
        if (state_q == ST_RUN) begin
            // ALU flags first so a status op below overrides them.
            if (alu_flag_we) begin
                sr_d[2:0] = {alu_carry, alu_sign, alu_zero};
            end
            if (accept) begin
                if (op_code == OP_TRAP) begin
                    epc_d          = pc_inc;
                    sr_d[SR_TRAP]  = 1'b1;
                end else if (op_code == OP_LDSR) begin
                    sr_d[3:0] = op_imm;
                    pc_d      = pc_inc;
                end else if (op_code == OP_XORSR) begin
                    sr_d[3:0] = sr_q[3:0] ^ op_imm;
                    pc_d      = pc_inc;
                end else if (is_jump && jump_taken) begin
                    pc_d       = jump_target;
                    redirect_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end else if (trap_ack) begin
            pc_d          = epc_q;
            sr_d[SR_TRAP] = 1'b0;
            redirect_d    = 1'b1;
        end
    end

    // Architectural registers; reset restores full-word mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= 20'd0;
            epc_q      <= 20'd0;
            sr_q       <= SR_RESET;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            sr_q       <= sr_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign sr       = sr_q;
    assign redirect = redirect_q;

endmodule

// File: doc/flow_ctrl.md
FLOW_CTRL -- requirements
Module: flow_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: clk samples on rising edge; rst acts immediately on assertion, independent of clk.
REQ-002 Ports, one per entry (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- op_valid  in  1  flow op offered
- op_ready  out  1  flow op can be accepted
- op_code  in  3  0 TRAP, 1 NOP, 2 JMP, 3 JZ, 4 JS, 5 JZS, 6 LDSR, 7 XORSR
- op_target  in  20  jump target
- op_imm  in  4  status immediate for LDSR/XORSR
- alu_flag_we  in  1  ALU flag update strobe
- alu_zero / alu_sign / alu_carry  in  1 each  ALU flags
- trap_ack  in  1  trap release
- pc  out  20  program counter
- sr  out  5  status {trap, mode, carry, sign, zero}
- epc  out  20  trap return address
- redirect  out  1  one-cycle pulse on PC redirect

Function
REQ-003 SHALL accept an op on a rising clk edge when op_valid && op_ready; no other op is acted on.
REQ-004 SHALL implement states RUN and TRAP; op_ready = 1 in RUN, 0 in TRAP (combinational from state).
REQ-005 sr bits SHALL be: [0] zero, [1] sign, [2] carry, [3] mode (1 = full 20-bit word, 0 = half 10-bit word), [4] trap; mode is output to the ALU.
REQ-006 alu_flag_we in RUN SHALL load sr[2:0] <= {alu_carry, alu_sign, alu_zero} at the edge; ignored in TRAP.
REQ-007 Jump conditions SHALL use registered sr before the edge: JMP always; JZ if sr[0]; JS if sr[1]; JZS if sr[0] | sr[1].
REQ-008 Taken jump target SHALL be op_target when sr[3] = 1, {10'b0, op_target[9:0]} when sr[3] = 0.
REQ-009 Taken jump: pc <= target; redirect = 1 in the following cycle only.
REQ-010 NOP, untaken jump, LDSR, XORSR: pc <= pc + 1 modulo 2^20 (20'hFFFFF wraps to 0); redirect = 0.
REQ-011 LDSR SHALL set sr[3:0] <= op_imm; XORSR SHALL set sr[3:0] <= sr[3:0] ^ op_imm; sr[4] is not writable by either.
REQ-012 If LDSR/XORSR is accepted in the same cycle as alu_flag_we, the op result SHALL win for all of sr[3:0].
REQ-013 TRAP accept SHALL set epc <= pc + 1 (mod 2^20), sr[4] <= 1, state <= TRAP; pc holds.
REQ-014 In TRAP, trap_ack SHALL set pc <= epc, sr[4] <= 0, state <= RUN, redirect = 1 in the following cycle; trap_ack in RUN SHALL be ignored.
REQ-015 Latency: every accepted op completes in one cycle; no op is queued or buffered; op_valid with op_ready = 0 has no effect.
REQ-016 With no accepted op and no trap_ack, pc, epc and sr[4:3] SHALL hold.

Reset
REQ-017 rst SHALL force: pc = 0, epc = 0, sr = 5'b01000 (full-word mode, flags clear, no trap), state = RUN, redirect = 0, op_ready = 1.
REQ-018 rst asserted mid-trap or coincident with an accepted op SHALL override; the op has no effect.
REQ-019 First op SHALL be accepted on the first rising clk edge after rst deasserts.

Verification
REQ-020 Reset, then 3 NOPs -> pc = 3, sr = 5'h08, redirect never set.
REQ-021 alu_flag_we with zero = 1; then JZ target 20'h12345 -> pc = 20'h12345, redirect pulses 1 cycle. Same with zero = 0 -> pc + 1.
REQ-022 LDSR imm 4'b0010 (half mode, sign = 1); then JS target 20'hABCDE -> pc = 20'h000DE.
REQ-023 pc = 20'h00040; TRAP -> epc = 20'h00041, sr[4] = 1, op_ready = 0; JMP offered -> ignored; trap_ack -> pc = 20'h00041, sr[4] = 0, redirect pulse.
REQ-024 pc = 20'hFFFFF; NOP -> pc = 0. XORSR 4'b1111 with simultaneous alu_flag_we -> sr[3:0] = old ^ 4'hF.
REQ-025 rst pulsed asynchronously mid-TRAP -> all outputs at reset values before the next clk edge.
